// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between instruction fetch and data access.
// Completed results are tagged and held so a stalled pipeline never re-issues an access.
//
// state  | meaning
// IDLE   | no bus cycle outstanding; picks data miss over fetch miss
// DATA   | data-port bus cycle in flight, waiting for ack or watchdog
// IFETCH | fetch-port bus cycle in flight, waiting for ack or watchdog
module mem_bus_arbiter #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_ce_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_data_o,
   input  logic        dm_ce_i,
   input  logic        dm_we_i,
   input  logic [3:0]  dm_sel_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_data_i,
   output logic [31:0] dm_data_o,
   input  logic        flush_i,
   output logic        stallreq_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_ack_i,
   output logic        bus_err_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, IFETCH = 2'd2} state_t;

   localparam logic [7:0] WD_LOAD = 8'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [7:0]  wd_cnt;
   logic        if_tag_valid;
   logic [31:0] if_tag_addr;
   logic        dm_tag_valid;
   logic [31:0] dm_tag_addr;
   logic        dm_tag_we;
   logic [3:0]  dm_tag_sel;
   logic [31:0] dm_tag_wdata;
   logic        discard;

   logic if_hit, dm_hit, if_miss, dm_miss;
   logic busy, done_ack, done_abort, done, start_dm, start_if, keep_result;

   assign if_hit  = if_ce_i & if_tag_valid & (if_tag_addr == if_addr_i);
   assign dm_hit  = dm_ce_i & dm_tag_valid & (dm_tag_addr == dm_addr_i) & (dm_tag_we == dm_we_i) &
                    (dm_tag_sel == dm_sel_i) & (dm_tag_wdata == dm_data_i);
   assign if_miss = if_ce_i & ~if_hit;
   assign dm_miss = dm_ce_i & ~dm_hit;
   assign stallreq_o = if_miss | dm_miss;

   assign busy        = (state != IDLE);
   assign done_ack    = busy & bus_ack_i;
   // an ack in the terminal-count cycle wins over the abort
   assign done_abort  = busy & ~bus_ack_i & (wd_cnt == 8'd0);
   assign done        = done_ack | done_abort;
   assign start_dm    = (state == IDLE) & dm_miss & ~flush_i;
   assign start_if    = (state == IDLE) & ~dm_miss & if_miss & ~flush_i;
   assign keep_result = ~discard & ~flush_i;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start_dm)      state_nxt = DATA;
            else if (start_if) state_nxt = IFETCH;
         end
         DATA, IFETCH: if (done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus_req_o = busy;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus_we_o     <= 1'b0;
         bus_sel_o    <= 4'h0;
         bus_addr_o   <= 32'h0;
         bus_wdata_o  <= 32'h0;
         bus_err_o    <= 1'b0;
         wd_cnt       <= 8'd0;
         discard      <= 1'b0;
         if_data_o    <= 32'h0;
         dm_data_o    <= 32'h0;
         if_tag_valid <= 1'b0;
         if_tag_addr  <= 32'h0;
         dm_tag_valid <= 1'b0;
         dm_tag_addr  <= 32'h0;
         dm_tag_we    <= 1'b0;
         dm_tag_sel   <= 4'h0;
         dm_tag_wdata <= 32'h0;
      end else begin
         bus_err_o <= done_abort;

         if (start_dm) begin
            bus_we_o    <= dm_we_i;
            bus_sel_o   <= dm_sel_i;
            bus_addr_o  <= dm_addr_i;
            bus_wdata_o <= dm_data_i;
            wd_cnt      <= WD_LOAD;
         end else if (start_if) begin
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'hF;
            bus_addr_o  <= if_addr_i;
            bus_wdata_o <= 32'h0;
            wd_cnt      <= WD_LOAD;
         end else if (done) begin
            wd_cnt <= 8'd0;
         end else if (busy) begin
            wd_cnt <= wd_cnt - 8'd1;
         end

         // a flush seen mid-cycle poisons that cycle's result
         if (busy) begin
            if (done)         discard <= 1'b0;
            else if (flush_i) discard <= 1'b1;
         end

         if (done && keep_result) begin
            if (state == IFETCH) begin
               if_data_o    <= done_ack ? bus_rdata_i : 32'h0;
               if_tag_valid <= 1'b1;
               if_tag_addr  <= bus_addr_o;
            end else begin
               if (done_abort || !bus_we_o) dm_data_o <= done_ack ? bus_rdata_i : 32'h0;
               dm_tag_valid <= 1'b1;
               dm_tag_addr  <= bus_addr_o;
               dm_tag_we    <= bus_we_o;
               dm_tag_sel   <= bus_sel_o;
               dm_tag_wdata <= bus_wdata_o;
            end
         end

         if (done_ack && (state == DATA) && bus_we_o && (bus_addr_o[31:2] == if_tag_addr[31:2]))
            if_tag_valid <= 1'b0;

         if (flush_i) begin
            if_tag_valid <= 1'b0;
            dm_tag_valid <= 1'b0;
         end
      end
   end

endmodule
